// File: rtl/fetch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_seq_ctrl
//
// Owns the architectural fetch PC and sequences instruction-memory fetches.
// Each returned instruction is held in a one-entry output register and handed
// to decode with a valid/ready handshake. Redirects from the branch unit are
// accepted in every state. A response belonging to the old path is dropped,
// and a held old-path instruction is flushed, so only the redirected stream
// reaches decode.
//
// Optional feature (compile-time macro FETCH_SEQ_MISALIGN_CHK_EN):
//   defined   : a redirect with target[1:0] != 0 pulses o_misalign for one
//               cycle and the target is force-aligned (target & ~3).
//   undefined : o_misalign is constant 0 and the target is used as given.
//
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_redirect/_pc           single-cycle redirect request and its target
//   i_imem_gnt               imem accepted the request this cycle
//   i_imem_rvalid/_rdata     imem response and instruction word
//   i_id_ready               decode consumes o_if_* this cycle
//   o_imem_req/_addr         fetch request and address (address = o_pc)
//   o_pc                     current fetch PC
//   o_if_valid/_pc/_inst     instruction held for decode
//   o_misalign               misaligned-redirect pulse
// -----------------------------------------------------------------------------
module fetch_seq_ctrl #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_id_ready,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_if_valid,
  output logic [WIDTH-1:0] o_if_pc,
  output logic [31:0]      o_if_inst,
  output logic             o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fpc_q, fpc_d;        // address of the outstanding fetch
  logic             kill_q, kill_d;      // outstanding response is wrong-path
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]      if_inst_q, if_inst_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] redirect_tgt;
  logic             misalign_hit;

`ifdef FETCH_SEQ_MISALIGN_CHK_EN
  assign redirect_tgt = {i_redirect_pc[WIDTH-1:2], 2'b00};
  assign misalign_hit = i_redirect & (i_redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = i_redirect_pc;
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fpc_d      = fpc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    misalign_d = misalign_hit;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (i_redirect) pc_d = redirect_tgt;
      end

      S_REQ: begin
        if (i_imem_gnt) begin
          fpc_d   = pc_q;
          state_d = S_WAIT;
          // The old request is already accepted: remember to drop its data.
          if (i_redirect) begin
            pc_d   = redirect_tgt;
            kill_d = 1'b1;
          end
        end else if (i_redirect) begin
          pc_d = redirect_tgt;
        end
      end

      S_WAIT: begin
        if (i_imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || i_redirect) begin
            // Wrong-path response: discard and refetch from the current pc.
            state_d = S_REQ;
            if (i_redirect) pc_d = redirect_tgt;
          end else begin
            if_valid_d = 1'b1;
            if_inst_d  = i_imem_rdata;
            if_pc_d    = fpc_q;
            pc_d       = fpc_q + WIDTH'(4);
            state_d    = S_HOLD;
          end
        end else if (i_redirect) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        // Redirect and handshake both release the entry; redirect also
        // replaces the sequential pc with the target.
        if (i_redirect || i_id_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
          if (i_redirect) pc_d = redirect_tgt;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fpc_q      <= '0;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fpc_q      <= fpc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;
  assign o_if_valid  = if_valid_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_inst   = if_inst_q;
  assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_seq_ctrl;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          NCYC    = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic [63:0] o_pc;
  logic        o_if_valid;
  logic [63:0] o_if_pc;
  logic [31:0] o_if_inst;
  logic        o_misalign;

  // wrap-around DUT signals
  logic        redirect2 = 1'b0;
  logic [63:0] redirect_pc2 = 64'h0;
  logic        gnt2 = 1'b1;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h0000_0013;
  logic        ready2 = 1'b1;
  logic        o_imem_req2;
  logic [63:0] o_imem_addr2;
  logic [63:0] o_pc2;
  logic        o_if_valid2;
  logic [63:0] o_if_pc2;
  logic [31:0] o_if_inst2;
  logic        o_misalign2;

  fetch_seq_ctrl #(.WIDTH(64), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_id_ready(id_ready),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .o_pc(o_pc),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc), .o_if_inst(o_if_inst),
    .o_misalign(o_misalign)
  );

  fetch_seq_ctrl #(.WIDTH(64), .RESET_PC(WRAP_PC)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
    .i_imem_gnt(gnt2), .i_imem_rvalid(rvalid2), .i_imem_rdata(rdata2),
    .i_id_ready(ready2),
    .o_imem_req(o_imem_req2), .o_imem_addr(o_imem_addr2), .o_pc(o_pc2),
    .o_if_valid(o_if_valid2), .o_if_pc(o_if_pc2), .o_if_inst(o_if_inst2),
    .o_misalign(o_misalign2)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: the program-order PC stream decode must see next.
  logic [63:0] exp_q[$];
  logic [63:0] exp_last;
  logic        mis_exp = 1'b0;
  logic        in_reset = 1'b1;
  int          ncyc = 0;
  int          pres_n = 0;
  int          pres_t[3];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_if_valid", {63'h0, o_if_valid}, 64'h0);
    chk("rst_if_pc", o_if_pc, 64'h0);
    chk("rst_if_inst", {32'h0, o_if_inst}, 64'h0);
    chk("rst_misalign", {63'h0, o_misalign}, 64'h0);
    chk("rst_req", {63'h0, o_imem_req}, 64'h0);
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_pc_wrap", o_pc2, WRAP_PC);
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_last = RST_PC;
    exp_q.push_back(exp_last);
    mis_exp = 1'b0;
  endtask

  // Main driver with imem model.
  initial begin : driver
    logic        cur_req;
    logic [63:0] cur_addr;
    logic        pend_valid;
    logic [63:0] pend_addr;
    int          pend_delay;
    logic [63:0] tgt_eff;
    bit          directed;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    cur_req = 1'b0; cur_addr = '0; pend_valid = 1'b0; pend_addr = '0; pend_delay = 0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    // A stray response during IDLE must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    in_reset    = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      directed = (cyc < 40);

      // Account for what happened at the edge just passed.
      if (imem_rvalid) pend_valid = 1'b0;
      if (cur_req && imem_gnt) begin
        pend_valid = 1'b1;
        pend_addr  = cur_addr;
        pend_delay = directed ? 0 : $urandom_range(0, 4);
      end
      if (redirect) begin
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
        tgt_eff = redirect_pc & ~64'h3;
        mis_exp = (redirect_pc[1:0] != 2'b00);
`else
        tgt_eff = redirect_pc;
        mis_exp = 1'b0;
`endif
        exp_q.delete();
        exp_last = tgt_eff;
        exp_q.push_back(exp_last);
      end else begin
        mis_exp = 1'b0;
      end
      while (exp_q.size() < 16) begin
        exp_last = exp_last + 64'd4;
        exp_q.push_back(exp_last);
      end

      if (cyc == NCYC / 2) begin
        // Asynchronous reset in the middle of traffic.
        in_reset = 1'b1;
        rst_n = 1'b0;
        redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        cur_req = 1'b0;
        pend_valid = 1'b0;
        reset_model();
        in_reset = 1'b0;
        continue;
      end

      // Drive the next cycle.
      cur_req  = o_imem_req;
      cur_addr = o_imem_addr;
      if (cur_req) chk("one_outstanding", {63'h0, pend_valid}, 64'h0);

      if (directed) begin
        redirect = 1'b0;
        imem_gnt = 1'b1;
        id_ready = 1'b1;
      end else begin
        redirect = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 29) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        else
          redirect_pc = 64'h8000_0000 + {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
        imem_gnt = ($urandom_range(0, 3) != 0);
        id_ready = ($urandom_range(0, 2) != 0);
      end

      if (pend_valid && pend_delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = inst_of(pend_addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend_valid) pend_delay--;
      end
    end

    redirect = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (pres_n >= 3) begin
      chk("thru_0_1", 64'(pres_t[1] - pres_t[0]), 64'd3);
      chk("thru_1_2", 64'(pres_t[2] - pres_t[1]), 64'd3);
    end else begin
      chk("thru_count", 64'(pres_n), 64'd3);
    end
    chk("min_delivered", {63'h0, (pres_n > 100)}, 64'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: pops the scoreboard whenever a new instruction is presented.
  initial begin : monitor
    logic        prev_valid;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic [63:0] e;
    prev_valid = 1'b0; prev_pc = '0; prev_inst = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (in_reset) begin
        prev_valid = 1'b0;
      end else begin
        if (o_if_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=pc %h required=a queued entry", o_if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", o_if_pc, e);
            chk("if_inst", {32'h0, o_if_inst}, {32'h0, inst_of(e)});
          end
          if (pres_n < 3) pres_t[pres_n] = ncyc;
          pres_n++;
          $display("xact %0d pc=%h inst=%h", pres_n, o_if_pc, o_if_inst);
        end else if (o_if_valid && prev_valid) begin
          chk("hold_pc", o_if_pc, prev_pc);
          chk("hold_inst", {32'h0, o_if_inst}, {32'h0, prev_inst});
        end
        if (o_if_valid) chk("no_req_in_hold", {63'h0, o_imem_req}, 64'h0);
        chk("misalign", {63'h0, o_misalign}, {63'h0, mis_exp});
        prev_valid = o_if_valid;
        prev_pc    = o_if_pc;
        prev_inst  = o_if_inst;
      end
    end
  end

  // Responder for the wrap-around instance: rvalid one cycle after each grant.
  initial begin : wrap_imem
    logic r;
    forever begin
      @(negedge clk);
      r = o_imem_req2;
      @(posedge clk);
      #1;
      rvalid2 = r;
    end
  end

  // Wrap-around checker: fetch at 0xFFFF_FFFF_FFFF_FFFC must be followed by 0.
  initial begin : wrap_chk
    logic [63:0] a0, a1;
    int          na;
    bit          seen_if;
    na = 0; seen_if = 0; a0 = '0; a1 = '0;
    @(posedge rst_n);
    for (int i = 0; i < 40 && (na < 2 || !seen_if); i++) begin
      @(negedge clk);
      if (o_imem_req2 && na < 2) begin
        if (na == 0) a0 = o_imem_addr2; else a1 = o_imem_addr2;
        na++;
      end
      if (o_if_valid2 && !seen_if) begin
        seen_if = 1;
        chk("wrap_if_pc", o_if_pc2, WRAP_PC);
        chk("wrap_if_inst", {32'h0, o_if_inst2}, 64'h13);
      end
    end
    chk("wrap_req_count", 64'(na), 64'd2);
    chk("wrap_first_addr", a0, WRAP_PC);
    chk("wrap_next_addr", a1, 64'h0);
    chk("wrap_seen_if", {63'h0, seen_if}, 64'h1);
    chk("wrap_misalign", {63'h0, o_misalign2}, 64'h0);
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Owns the architectural fetch PC and sequences instruction-memory fetches.
- Each fetched instruction is presented to decode through a one-entry output register with a valid/ready handshake.
- Accepts redirects (taken branch/jal/jalr target from the branch unit) at any point. Wrong-path responses and wrong-path output contents are discarded so that no wrong-path instruction reaches decode.

Parameters:
- WIDTH, 64, PC/address width (matches CPU_WIDTH).
- RESET_PC, 64'h0000_0000_8000_0000, first PC fetched after reset.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_redirect  input  1  redirect request (taken branch/jump), single-cycle pulse.
- i_redirect_pc  input  WIDTH  redirect target, valid with i_redirect.
- i_imem_gnt  input  1  imem accepted the request this cycle.
- i_imem_rvalid  input  1  imem response valid.
- i_imem_rdata  input  32  instruction word, valid with i_imem_rvalid.
- i_id_ready  input  1  decode consumes o_if_* this cycle.
- o_imem_req  output  1  fetch request.
- o_imem_addr  output  WIDTH  fetch address (= o_pc).
- o_pc  output  WIDTH  current fetch PC.
- o_if_valid  output  1  o_if_pc/o_if_inst hold a valid instruction.
- o_if_pc  output  WIDTH  PC of the held instruction.
- o_if_inst  output  32  held instruction.
- o_misalign  output  1  misaligned redirect pulse (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-low, applied on i_rst_n.
  - Reset values: state=IDLE, pc=RESET_PC, kill=0, o_if_valid=0, o_if_pc=0, o_if_inst=0, o_misalign=0.
  - o_imem_req=0 in IDLE.
  - Reset mid-fetch abandons any outstanding request. Any response arriving after reset release while in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD. All outputs are driven from registers or state; there are no combinational paths from inputs to outputs.
- o_imem_req=1 only in REQ. o_imem_addr=pc.
- IDLE:
  - Moves to REQ on the next clock.
  - A redirect in IDLE loads pc<=target.
- REQ:
  - Request stays asserted until i_imem_gnt.
  - gnt -> WAIT, with fpc<=pc (internal address of the outstanding fetch).
  - redirect without gnt: pc<=target, stay REQ. The new address appears on the next cycle.
  - redirect with gnt: the old request is accepted. pc<=target, kill<=1, -> WAIT.
- WAIT:
  - rvalid with kill=1: drop the response, kill<=0, -> REQ.
  - rvalid with kill=0 and no redirect:
    - o_if_valid<=1, o_if_inst<=rdata, o_if_pc<=fpc.
    - pc<=fpc+4, computed modulo 2^WIDTH (wraps to 0).
    - -> HOLD.
  - redirect without rvalid: pc<=target, kill<=1, stay WAIT.
  - redirect with rvalid: drop the response, pc<=target, kill<=0, -> REQ.
- HOLD:
  - i_id_ready (handshake completes): o_if_valid<=0, -> REQ.
  - redirect: o_if_valid<=0 (flush), pc<=target, -> REQ.
  - redirect takes priority over i_id_ready. If both are high, the instruction is treated as consumed by decode; the target is still taken.
  - Otherwise hold all outputs stable.
- i_id_ready is ignored when o_if_valid=0.
- At most one outstanding imem request at any time.
- Minimum throughput is one instruction per 3 cycles with zero-latency gnt and 1-cycle rvalid.
- Redirect-to-first-request latency is 1 cycle from REQ or HOLD. From WAIT, the request is issued after the pending response returns.

Optional Feature:
- Macro: FETCH_SEQ_MISALIGN_CHK_EN.
- Defined:
  - A redirect with i_redirect_pc[1:0]!=0 sets o_misalign=1 for exactly one cycle (the cycle after the redirect).
  - The redirect is still taken, with pc<=target & ~3.
- Undefined:
  - o_misalign is tied to 0.
  - The target is loaded unmodified.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, rdata=32'h00000013, id_ready=1 -> o_imem_addr sequence 0x80000000, 0x80000004, 0x80000008. o_if_pc matches each address, one per 3 cycles.
- Redirect to 0x80001000 in the cycle gnt is given for 0x80000004 -> that response is dropped. Next request addr=0x80001000. o_if_valid never shows pc 0x80000004.
- In HOLD with o_if_pc=0x80000000, id_ready=0 for 5 cycles -> outputs stable, no request. Then redirect=1 with id_ready=1, target 0x80000200 -> o_if_valid=0 next cycle, then request addr=0x80000200.
- Redirect in WAIT while rvalid is delayed 4 cycles, target 0x80000400 -> the late response is dropped, then a single request to 0x80000400.
- RESET_PC=64'hFFFFFFFFFFFFFFFC, one fetch -> next request addr=0.
- With FETCH_SEQ_MISALIGN_CHK_EN, redirect to 0x80000002 -> o_misalign=1 for one cycle, next addr=0x80000000. Without the macro, o_misalign stays 0 and next addr=0x80000002.
